// File: rtl/stat_dump_pkg.sv
// stat_dump_pkg: shared types and constants for the performance-counter dump
// block (state encoding, counter word indices, frame sizes, header tag).
package stat_dump_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR  = 2'd1,
    DATA = 2'd2,
    CSUM = 2'd3
  } state_e;

  localparam int unsigned NUM_CTRS = 11;

  localparam logic [3:0] IDX_COUNT       = 4'd0;
  localparam logic [3:0] IDX_CYC_COUNT   = 4'd1;
  localparam logic [3:0] IDX_TIME_COUNT  = 4'd2;
  localparam logic [3:0] IDX_IMISS_COUNT = 4'd3;
  localparam logic [3:0] IDX_DMISS_COUNT = 4'd4;
  localparam logic [3:0] IDX_IACCESSES   = 4'd5;
  localparam logic [3:0] IDX_DACCESSES   = 4'd6;
  localparam logic [3:0] IDX_PREDICTED   = 4'd7;
  localparam logic [3:0] IDX_PCORRECT    = 4'd8;
  localparam logic [3:0] IDX_SPEC_IABORT = 4'd9;
  localparam logic [3:0] IDX_SPEC_DABORT = 4'd10;

  localparam logic [7:0] NWORDS_CSUM   = 8'd13;
  localparam logic [7:0] NWORDS_NOCSUM = 8'd12;

  localparam logic [7:0] HDR_TAG_DEFAULT = 8'hA5;

  // Saturating 8-bit increment (holds at FF).
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/stat_dump_snap.sv
// stat_dump_snap: 11 x 32-bit snapshot register bank.
// Ports:
//   clk, rst_n  - clock, async active-low reset (clears all entries)
//   load        - capture all of ctr_in on this edge
//   ctr_in      - packed counter vector, entry i = word index i
//   rd_idx      - read index; out-of-range indices read as zero
//   rd_data     - selected snapshot entry
module stat_dump_snap
  import stat_dump_pkg::*;
(
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           load,
  input  logic [NUM_CTRS-1:0][31:0]      ctr_in,
  input  logic [3:0]                     rd_idx,
  output logic [31:0]                    rd_data
);

  logic [NUM_CTRS-1:0][31:0] snap_q, snap_d;

  always_comb begin
    snap_d = snap_q;
    if (load) snap_d = ctr_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) snap_q <= '0;
    else        snap_q <= snap_d;
  end

  always_comb begin
    rd_data = '0;
    if (32'(rd_idx) < NUM_CTRS) rd_data = snap_q[rd_idx];
  end

endmodule

// File: rtl/stat_dump.sv
// stat_dump: snapshots the 11 core performance counters and streams them as a
// framed sequence of 32-bit words over valid/ready.
// Frame: header {HDR_TAG, seq, nwords, 8'h00}, 11 counter words, and, when
// built with STAT_DUMP_CSUM_EN, a trailing XOR checksum of all prior words.
// Ports:
//   nGCLK, nRESET      - clock (posedge), async active-low reset
//   dump_req           - dump request, one per high cycle
//   count..spec_dabort - counter inputs, word indices 0..10
//   dump_ready         - sink accepts the current word
//   dump_valid/data/last - word output, last marks the final frame word
//   busy               - frame in progress
//   drop_count         - saturating count of lost requests
// Parameters: HDR_TAG (header tag), AUTO_PERIOD (auto dump period, 0 = off).
// Macro: STAT_DUMP_CSUM_EN adds the checksum word.
module stat_dump
  import stat_dump_pkg::*;
#(
  parameter logic [7:0]  HDR_TAG     = HDR_TAG_DEFAULT,
  parameter int unsigned AUTO_PERIOD = 0
) (
  input  logic        nGCLK,
  input  logic        nRESET,
  input  logic        dump_req,
  input  logic [31:0] count,
  input  logic [31:0] cyc_count,
  input  logic [31:0] time_count,
  input  logic [31:0] imiss_count,
  input  logic [31:0] dmiss_count,
  input  logic [31:0] iaccesses,
  input  logic [31:0] daccesses,
  input  logic [31:0] predicted,
  input  logic [31:0] pcorrect,
  input  logic [31:0] spec_iabort,
  input  logic [31:0] spec_dabort,
  input  logic        dump_ready,
  output logic        dump_valid,
  output logic [31:0] dump_data,
  output logic        dump_last,
  output logic        busy,
  output logic [7:0]  drop_count
);

`ifdef STAT_DUMP_CSUM_EN
  localparam logic [7:0] NWORDS = NWORDS_CSUM;
`else
  localparam logic [7:0] NWORDS = NWORDS_NOCSUM;
`endif

  localparam bit          AUTO_EN   = (AUTO_PERIOD != 0);
  localparam logic [31:0] AUTO_LAST = AUTO_EN ? 32'(AUTO_PERIOD - 1) : '0;

  state_e      state_q, state_d;
  logic [3:0]  idx_q, idx_d;
  logic [7:0]  seq_q, seq_d;
  logic        pending_q, pending_d;
  logic [7:0]  drop_q, drop_d;
  logic [31:0] timer_q, timer_d;
`ifdef STAT_DUMP_CSUM_EN
  logic [31:0] csum_q, csum_d;
`endif

  logic                      auto_tick;
  logic                      new_req;
  logic                      xfer;
  logic                      snap_load;
  logic [31:0]               snap_rd;
  logic [31:0]               header;
  logic [NUM_CTRS-1:0][31:0] ctr_in;

  always_comb begin
    ctr_in                  = '0;
    ctr_in[IDX_COUNT]       = count;
    ctr_in[IDX_CYC_COUNT]   = cyc_count;
    ctr_in[IDX_TIME_COUNT]  = time_count;
    ctr_in[IDX_IMISS_COUNT] = imiss_count;
    ctr_in[IDX_DMISS_COUNT] = dmiss_count;
    ctr_in[IDX_IACCESSES]   = iaccesses;
    ctr_in[IDX_DACCESSES]   = daccesses;
    ctr_in[IDX_PREDICTED]   = predicted;
    ctr_in[IDX_PCORRECT]    = pcorrect;
    ctr_in[IDX_SPEC_IABORT] = spec_iabort;
    ctr_in[IDX_SPEC_DABORT] = spec_dabort;
  end

  stat_dump_snap u_snap (
    .clk     (nGCLK),
    .rst_n   (nRESET),
    .load    (snap_load),
    .ctr_in  (ctr_in),
    .rd_idx  (idx_q),
    .rd_data (snap_rd)
  );

  always_comb begin
    auto_tick  = AUTO_EN && (timer_q == AUTO_LAST);
    new_req    = dump_req | auto_tick;
    header     = {HDR_TAG, seq_q, NWORDS, 8'h00};
    dump_valid = (state_q != IDLE);
    busy       = (state_q != IDLE);
    drop_count = drop_q;
    xfer       = dump_valid & dump_ready;

    state_d    = state_q;
    idx_d      = idx_q;
    seq_d      = seq_q;
    pending_d  = pending_q;
    drop_d     = drop_q;
    timer_d    = '0;
    snap_load  = 1'b0;
    dump_data  = '0;
    dump_last  = 1'b0;
`ifdef STAT_DUMP_CSUM_EN
    csum_d     = csum_q;
`endif

    if (AUTO_EN && !auto_tick) timer_d = timer_q + 32'd1;

    case (state_q)
      IDLE: begin
        if (new_req || pending_q) begin
          snap_load = 1'b1;
          pending_d = 1'b0;
          state_d   = HDR;
        end
      end
      HDR: begin
        dump_data = header;
        if (xfer) begin
          state_d = DATA;
          idx_d   = '0;
`ifdef STAT_DUMP_CSUM_EN
          csum_d  = header;
`endif
        end
      end
      DATA: begin
        dump_data = snap_rd;
`ifndef STAT_DUMP_CSUM_EN
        dump_last = (idx_q == IDX_SPEC_DABORT);
`endif
        if (xfer) begin
`ifdef STAT_DUMP_CSUM_EN
          csum_d = csum_q ^ snap_rd;
`endif
          if (idx_q == IDX_SPEC_DABORT) begin
`ifdef STAT_DUMP_CSUM_EN
            state_d = CSUM;
`else
            state_d = IDLE;
            seq_d   = seq_q + 8'd1;
`endif
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end
      end
`ifdef STAT_DUMP_CSUM_EN
      CSUM: begin
        dump_data = csum_q;
        dump_last = 1'b1;
        if (xfer) begin
          state_d = IDLE;
          seq_d   = seq_q + 8'd1;
        end
      end
`endif
      default: state_d = IDLE;
    endcase

    // A request seen while a frame is active (including its final transfer
    // edge) is queued once; further ones are counted as dropped.
    if (state_q != IDLE && new_req) begin
      if (!pending_q) pending_d = 1'b1;
      else            drop_d    = sat_inc8(drop_q);
    end
  end

  always_ff @(posedge nGCLK or negedge nRESET) begin
    if (!nRESET) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      seq_q     <= '0;
      pending_q <= 1'b0;
      drop_q    <= '0;
      timer_q   <= '0;
`ifdef STAT_DUMP_CSUM_EN
      csum_q    <= '0;
`endif
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      seq_q     <= seq_d;
      pending_q <= pending_d;
      drop_q    <= drop_d;
      timer_q   <= timer_d;
`ifdef STAT_DUMP_CSUM_EN
      csum_q    <= csum_d;
`endif
    end
  end

endmodule

// File: tb/tb_stat_dump.sv
module tb_stat_dump;

  localparam logic [7:0] TAG = 8'hA5;
`ifdef STAT_DUMP_CSUM_EN
  localparam int NW = 13;
`else
  localparam int NW = 12;
`endif

  logic        nGCLK = 1'b0;
  logic        nRESET = 1'b0;
  logic        dump_req = 1'b0;
  logic        dump_ready = 1'b1;
  logic [31:0] ctr [11];

  logic        dump_valid, dump_last, busy;
  logic [31:0] dump_data;
  logic [7:0]  drop_count;
  logic        a_valid, a_last, a_busy;
  logic [31:0] a_data;
  logic [7:0]  a_drop;

  int total = 0;
  int bad   = 0;

  always #5 nGCLK = ~nGCLK;

  stat_dump dut (
    .nGCLK(nGCLK), .nRESET(nRESET), .dump_req(dump_req),
    .count(ctr[0]), .cyc_count(ctr[1]), .time_count(ctr[2]),
    .imiss_count(ctr[3]), .dmiss_count(ctr[4]), .iaccesses(ctr[5]),
    .daccesses(ctr[6]), .predicted(ctr[7]), .pcorrect(ctr[8]),
    .spec_iabort(ctr[9]), .spec_dabort(ctr[10]),
    .dump_ready(dump_ready), .dump_valid(dump_valid), .dump_data(dump_data),
    .dump_last(dump_last), .busy(busy), .drop_count(drop_count)
  );

  stat_dump #(.AUTO_PERIOD(20)) dut_a (
    .nGCLK(nGCLK), .nRESET(nRESET), .dump_req(1'b0),
    .count(ctr[0]), .cyc_count(ctr[1]), .time_count(ctr[2]),
    .imiss_count(ctr[3]), .dmiss_count(ctr[4]), .iaccesses(ctr[5]),
    .daccesses(ctr[6]), .predicted(ctr[7]), .pcorrect(ctr[8]),
    .spec_iabort(ctr[9]), .spec_dabort(ctr[10]),
    .dump_ready(1'b1), .dump_valid(a_valid), .dump_data(a_data),
    .dump_last(a_last), .busy(a_busy), .drop_count(a_drop)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Scoreboard: {last, data} per expected word.
  logic [32:0] exp_q[$];
  logic [7:0]  seq_m  = 8'h00;
  logic [7:0]  drop_m = 8'h00;
  bit          pend_m = 1'b0;
  int          ready_mode = 0;

  function automatic void push_frame();
    logic [31:0] h, x;
    h = {TAG, seq_m, 8'(NW), 8'h00};
    x = h;
    exp_q.push_back({1'b0, h});
    for (int i = 0; i < 11; i++) begin
      x = x ^ ctr[i];
      exp_q.push_back({(NW == 12 && i == 10), ctr[i]});
    end
    if (NW == 13) exp_q.push_back({1'b1, x});
    seq_m = seq_m + 8'd1;
  endfunction

  // Ready pattern driver: 0 = always ready, 1 = toggle, other = stalled.
  initial forever begin
    @(posedge nGCLK);
    #1;
    case (ready_mode)
      0:       dump_ready = 1'b1;
      1:       dump_ready = ~dump_ready;
      default: dump_ready = 1'b0;
    endcase
  end

  // Main monitor.
  int  wcnt = 0;
  bit  after_last = 0;
  bit  counting_gap = 0;
  int  gap = 0;
  int  last_gap = -1;
  always @(negedge nGCLK) begin
    if (!nRESET) begin
      wcnt = 0; after_last = 0; counting_gap = 0; gap = 0;
    end else begin
      if (after_last) begin
        check("valid_after_last", dump_valid, 1'b0);
        after_last = 0;
      end
      if (dump_valid) begin
        if (counting_gap) begin last_gap = gap; counting_gap = 0; end
        check("busy_with_valid", busy, 1'b1);
        if (exp_q.size() == 0) begin
          check("spurious_valid", dump_valid, 1'b0);
        end else begin
          check("word", {dump_last, dump_data}, exp_q[0]);
          if (dump_ready) begin
            logic [32:0] w;
            w = exp_q.pop_front();
            wcnt++;
            if (w[32]) begin
              after_last = 1; wcnt = 0; counting_gap = 1; gap = 0;
            end
          end
        end
      end else if (counting_gap) begin
        gap++;
      end
    end
  end

  // Auto-trigger instance monitor.
  int         cyc = 0;
  int         a_w = 0, a_t = 0, a_hdrs = 0;
  bit         a_has = 0;
  logic [7:0] a_seq = 8'h00;
  always @(posedge nGCLK) cyc++;
  always @(negedge nGCLK) begin
    if (!nRESET) begin
      a_w = 0; a_seq = 8'h00; a_has = 0;
    end else if (a_valid) begin
      if (a_w == 0) begin
        check("auto_hdr", a_data, {TAG, a_seq, 8'(NW), 8'h00});
        if (a_has) check("auto_period", cyc - a_t, 20);
        a_t = cyc; a_has = 1; a_hdrs++;
      end
      check("auto_last", a_last, (a_w == NW - 1));
      a_w++;
      if (a_w == NW) begin a_w = 0; a_seq = a_seq + 8'd1; end
    end
  end

  task automatic req_pulse();
    @(posedge nGCLK); #1;
    dump_req = 1'b1;
    push_frame();
    @(posedge nGCLK); #1;
    dump_req = 1'b0;
  endtask

  task automatic req_busy(input int n);
    repeat (n) begin
      @(posedge nGCLK); #1;
      dump_req = 1'b1;
      if (!pend_m) begin
        pend_m = 1'b1;
        push_frame();
      end else begin
        drop_m = (drop_m == 8'hFF) ? 8'hFF : drop_m + 8'd1;
      end
    end
    @(posedge nGCLK); #1;
    dump_req = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || dump_valid) && n < budget) begin
      @(negedge nGCLK); #2;
      n++;
    end
    if (n >= budget) check("idle_timeout", 64'(exp_q.size()), 64'd0);
    pend_m = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got=running exp=finished");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 11; i++) ctr[i] = 32'h1000_0000 + 32'(i);
    repeat (2) @(posedge nGCLK);
    @(negedge nGCLK);
    check("rst_valid", dump_valid, 1'b0);
    check("rst_data",  dump_data,  32'h0);
    check("rst_last",  dump_last,  1'b0);
    check("rst_busy",  busy,       1'b0);
    check("rst_drop",  drop_count, 8'h00);
    #2 nRESET = 1'b1;

    // Basic frame, sink always ready.
    ready_mode = 0;
    req_pulse();
    check("latency", dump_valid, 1'b1);
    wait_idle(100);
    check("busy_after_frame", busy, 1'b0);

    // Toggled ready; inputs change mid-frame.
    ready_mode = 1;
    req_pulse();
    repeat (4) @(posedge nGCLK);
    #1;
    for (int i = 0; i < 11; i++) ctr[i] = 32'hDEAD_0000 + 32'(i);
    wait_idle(200);
    ready_mode = 0;

    // Requests while stalled: one pending, two drops, then 1-cycle gap.
    ready_mode = 2;
    @(posedge nGCLK);
    req_pulse();
    repeat (2) @(posedge nGCLK);
    req_busy(1);
    req_busy(1);
    req_busy(1);
    @(negedge nGCLK); #2;
    check("drop_two", drop_count, drop_m);
    ready_mode = 0;
    wait_idle(200);
    check("frame_gap", last_gap, 1);

    // 256 frames: sequence wrap via scoreboard headers.
    for (int f = 0; f < 256; f++) begin
      ctr[f % 11] = 32'($urandom);
      req_pulse();
      wait_idle(100);
    end

    // Drop counter saturation.
    ready_mode = 2;
    @(posedge nGCLK);
    req_pulse();
    req_busy(301);
    @(negedge nGCLK); #2;
    check("drop_sat", drop_count, drop_m);
    ready_mode = 0;
    wait_idle(300);

    // Reset mid-frame at data index 5.
    req_pulse();
    begin
      int n = 0;
      while (wcnt != 6 && n < 50) begin @(negedge nGCLK); #2; n++; end
      check("reach_idx5", wcnt, 6);
    end
    @(posedge nGCLK); #2;
    nRESET = 1'b0;
    #1;
    check("mid_rst_valid", dump_valid, 1'b0);
    check("mid_rst_data",  dump_data,  32'h0);
    check("mid_rst_last",  dump_last,  1'b0);
    check("mid_rst_busy",  busy,       1'b0);
    check("mid_rst_drop",  drop_count, 8'h00);
    exp_q.delete();
    seq_m = 8'h00; drop_m = 8'h00; pend_m = 1'b0;
    repeat (2) @(posedge nGCLK);
    #3 nRESET = 1'b1;
    repeat (5) @(negedge nGCLK);
    #2;
    check("no_valid_after_rst", dump_valid, 1'b0);
    req_pulse();
    wait_idle(100);

    // Let the auto-trigger instance run a few more periods.
    repeat (60) @(posedge nGCLK);
    check("auto_frames_seen", (a_hdrs > 10), 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
